pulse_counter_multi: RTL and testbench

Parametrised successor to the 4-button pulse adder. Provides N_CH independent press counters. Each channel has:
- a 2-FF input synchroniser,
- a per-channel debounce filter,
- rising-edge press detection,
- an up/down counter with selectable wrap or saturate mode and a sticky overflow flag.

It sits between the board push-buttons and the display/LED logic on the expansion board.

---
 rtl/pulse_counter_multi.sv | 106 ++++++++++
 tb/tb_pulse_counter_multi.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_counter_multi.sv
// N_CH independent button press counters: 2-FF synchroniser, debounce filter,
// rising-edge press detection and an up/down wrap-or-saturate counter with sticky overflow.
module pulse_counter_multi #(
   parameter int N_CH       = 4,
   parameter int CNT_W      = 4,
   parameter int DEB_CYCLES = 4,
   parameter int SATURATE   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         btn_in,
   input  logic                    dir_in,
   input  logic                    en_in,
   input  logic [N_CH-1:0]         clr_in,
   output logic [N_CH*CNT_W-1:0]   count_out,
   output logic [N_CH-1:0]         ovf_out,
   output logic [N_CH-1:0]         press_out
);

   localparam int                DCNT_W   = $clog2(DEB_CYCLES + 1);
   localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEB_CYCLES - 1);
   localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam bit                SAT_EN   = (SATURATE != 0);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic              s0_r, s1_r, filt_r, press_r, ovf_r;
      logic [DCNT_W-1:0] dcnt_r;
      logic [CNT_W-1:0]  cnt_r;
      logic              accept_s, rise_s, filt_nxt_s, ovf_nxt_s;
      logic [DCNT_W-1:0] dcnt_nxt_s;
      logic [CNT_W-1:0]  cnt_nxt_s;

      // Debounce next state, press detection and counter next state
      always_comb begin
         accept_s   = 1'b0;
         filt_nxt_s = filt_r;
         dcnt_nxt_s = dcnt_r;
         if (s1_r == filt_r) begin
            dcnt_nxt_s = {DCNT_W{1'b0}};
         end else if (dcnt_r == DEB_LAST) begin
            accept_s   = 1'b1;
            filt_nxt_s = s1_r;
            dcnt_nxt_s = {DCNT_W{1'b0}};
         end else begin
            dcnt_nxt_s = dcnt_r + DCNT_ONE;
         end
         rise_s = accept_s & s1_r;

         cnt_nxt_s = cnt_r;
         ovf_nxt_s = ovf_r;
         // Clear wins over a coincident press; the strobe is unaffected
         if (clr_in[i]) begin
            cnt_nxt_s = CNT_ZERO;
            ovf_nxt_s = 1'b0;
         end else if (rise_s && en_in) begin
            if (!dir_in) begin
               if (cnt_r == CNT_MAX) begin
                  cnt_nxt_s = SAT_EN ? CNT_MAX : CNT_ZERO;
                  ovf_nxt_s = 1'b1;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end else begin
               if (cnt_r == CNT_ZERO) begin
                  cnt_nxt_s = SAT_EN ? CNT_ZERO : CNT_MAX;
                  ovf_nxt_s = 1'b1;
               end else begin
                  cnt_nxt_s = cnt_r - CNT_ONE;
               end
            end
         end else begin
            cnt_nxt_s = cnt_r;
            ovf_nxt_s = ovf_r;
         end
      end

      // Channel state registers
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s0_r    <= 1'b0;
            s1_r    <= 1'b0;
            filt_r  <= 1'b0;
            dcnt_r  <= {DCNT_W{1'b0}};
            press_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
            ovf_r   <= 1'b0;
         end else begin
            s0_r    <= btn_in[i];
            s1_r    <= s0_r;
            filt_r  <= filt_nxt_s;
            dcnt_r  <= dcnt_nxt_s;
            press_r <= rise_s;
            cnt_r   <= cnt_nxt_s;
            ovf_r   <= ovf_nxt_s;
         end
      end

      assign count_out[i*CNT_W +: CNT_W] = cnt_r;
      assign ovf_out[i]                  = ovf_r;
      assign press_out[i]                = press_r;
   end

endmodule

// File: tb/tb_pulse_counter_multi.sv
// Bench for pulse_counter_multi: a wrap and a saturate instance share stimulus and are
// compared every cycle against a sample-history reference model, plus directed scenarios.
module tb_pulse_counter_multi;
   localparam int NC  = 4;
   localparam int CW  = 4;
   localparam int DB  = 4;
   localparam int MAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NC-1:0] btn = '0, clr = '0;
   logic dir = 1'b0, en = 1'b1;
   logic [NC*CW-1:0] cnt_w, cnt_s;
   logic [NC-1:0] ovf_w, ovf_s, prs_w, prs_s;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   pulse_counter_multi #(.N_CH(NC), .CNT_W(CW), .DEB_CYCLES(DB), .SATURATE(0)) dut_wrap (
      .clk(clk), .rst(rst), .btn_in(btn), .dir_in(dir), .en_in(en), .clr_in(clr),
      .count_out(cnt_w), .ovf_out(ovf_w), .press_out(prs_w));

   pulse_counter_multi #(.N_CH(NC), .CNT_W(CW), .DEB_CYCLES(DB), .SATURATE(1)) dut_sat (
      .clk(clk), .rst(rst), .btn_in(btn), .dir_in(dir), .en_in(en), .clr_in(clr),
      .count_out(cnt_s), .ovf_out(ovf_s), .press_out(prs_s));

   // Reference model: index 0 = wrap instance, 1 = saturate instance
   int  m_cnt [2][NC];
   bit  m_ovf [2][NC];
   bit  m_press [NC];
   bit  m_filt [NC];
   bit  m_d1 [NC], m_d2 [NC];
   bit  m_hist [NC][$];
   int  m_since [NC];
   int  strobes [NC];
   bit  all_seen;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         for (int k = 0; k < 2; k++) begin
            m_cnt[k][c] = 0;
            m_ovf[k][c] = 1'b0;
         end
         m_press[c] = 1'b0;
         m_filt[c]  = 1'b0;
         m_d1[c]    = 1'b0;
         m_d2[c]    = 1'b0;
         m_hist[c].delete();
         m_since[c] = 0;
      end
   endtask

   // A level is accepted once DB consecutive synchronised samples, all taken after the
   // previous acceptance, differ from the current filtered level.
   task automatic model_edge();
      bit all_diff, rise;
      int n;
      if (rst) begin
         model_reset();
         return;
      end
      for (int c = 0; c < NC; c++) begin
         m_hist[c].push_front(m_d2[c]);
         if (m_hist[c].size() > DB) void'(m_hist[c].pop_back());
         m_since[c]++;
         all_diff = (m_since[c] >= DB);
         foreach (m_hist[c][j]) if (m_hist[c][j] == m_filt[c]) all_diff = 1'b0;
         rise = 1'b0;
         if (all_diff) begin
            m_filt[c]  = ~m_filt[c];
            m_since[c] = 0;
            rise       = m_filt[c];
         end
         m_press[c] = rise;
         m_d2[c] = m_d1[c];
         m_d1[c] = btn[c];
         for (int k = 0; k < 2; k++) begin
            if (clr[c]) begin
               m_cnt[k][c] = 0;
               m_ovf[k][c] = 1'b0;
            end else if (rise && en) begin
               n = dir ? m_cnt[k][c] - 1 : m_cnt[k][c] + 1;
               if (n > MAX) begin
                  m_ovf[k][c] = 1'b1;
                  n = (k == 1) ? MAX : 0;
               end else if (n < 0) begin
                  m_ovf[k][c] = 1'b1;
                  n = (k == 1) ? 0 : MAX;
               end
               m_cnt[k][c] = n;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [NC*CW-1:0] ec [2];
      logic [NC-1:0] eo [2], ep;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < NC; c++) begin
            ec[k][c*CW +: CW] = CW'(m_cnt[k][c]);
            eo[k][c]          = m_ovf[k][c];
            ep[c]             = m_press[c];
         end
      end
      chk("wrap_count", 64'(cnt_w), 64'(ec[0]));
      chk("wrap_ovf",   64'(ovf_w), 64'(eo[0]));
      chk("wrap_press", 64'(prs_w), 64'(ep));
      chk("sat_count",  64'(cnt_s), 64'(ec[1]));
      chk("sat_ovf",    64'(ovf_s), 64'(eo[1]));
      chk("sat_press",  64'(prs_s), 64'(ep));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      for (int c = 0; c < NC; c++) if (prs_w[c]) strobes[c]++;
      if (prs_w == 4'hF) all_seen = 1'b1;
   endtask

   task automatic press(input logic [NC-1:0] mask, input int hi, input int lo);
      btn = mask;
      repeat (hi) step();
      btn = '0;
      repeat (lo) step();
   endtask

   task automatic clear_all();
      clr = 4'hF;
      step();
      clr = 4'h0;
   endtask

   logic [NC*CW-1:0] snap;
   logic [CW-1:0]    ch_val;

   initial begin
      model_reset();
      repeat (2) step();
      rst = 1'b0;
      chk("reset_count", 64'(cnt_w), 64'd0);
      chk("reset_flags", 64'({ovf_w, prs_w, ovf_s, prs_s}), 64'd0);

      // Press/wrap on channel 0
      for (int c = 0; c < NC; c++) strobes[c] = 0;
      dir = 1'b0; en = 1'b1;
      repeat (16) press(4'h1, 6, 6);
      chk("wrap16_count0", 64'(cnt_w[3:0]), 64'd0);
      chk("wrap16_ovf0",   64'(ovf_w[0]), 64'd1);
      chk("wrap16_strobes", 64'(strobes[0]), 64'd16);
      chk("wrap16_others", 64'(cnt_w[15:4]), 64'd0);

      // Glitch rejection on channel 1
      clear_all();
      press(4'h2, 3, 6);
      chk("glitch_count1", 64'(cnt_w[7:4]), 64'd0);
      btn = 4'h2;
      repeat (5) step();
      chk("glitch_early_press1", 64'(prs_w[1]), 64'd0);
      step();
      chk("glitch_press1_edge6", 64'(prs_w[1]), 64'd1);
      btn = '0;
      repeat (8) step();
      chk("glitch_count1_after", 64'(cnt_w[7:4]), 64'd1);

      // Down then up on channel 2: saturating instance clamps
      clear_all();
      dir = 1'b1;
      repeat (2) press(4'h4, 6, 6);
      chk("sat_down_count2", 64'(cnt_s[11:8]), 64'd0);
      chk("sat_down_ovf2",   64'(ovf_s[2]), 64'd1);
      dir = 1'b0;
      repeat (20) press(4'h4, 6, 6);
      chk("sat_up_count2",  64'(cnt_s[11:8]), 64'd15);
      chk("sat_up_ovf2",    64'(ovf_s[2]), 64'd1);
      chk("wrap_mix_count2", 64'(cnt_w[11:8]), 64'd2);

      // Clear priority on channel 3 with count 5 and ovf set
      clear_all();
      dir = 1'b1;
      press(4'h8, 6, 6);
      dir = 1'b0;
      repeat (6) press(4'h8, 6, 6);
      chk("pre_clr_count3", 64'(cnt_w[15:12]), 64'd5);
      chk("pre_clr_ovf3",   64'(ovf_w[3]), 64'd1);
      btn = 4'h8;
      repeat (5) step();
      clr = 4'h8;
      step();
      clr = 4'h0;
      chk("clr_press3", 64'(prs_w[3]), 64'd1);
      chk("clr_count3", 64'(cnt_w[15:12]), 64'd0);
      chk("clr_ovf3",   64'(ovf_w[3]), 64'd0);
      btn = '0;
      repeat (8) step();

      // Enable low then high with all channels together
      snap = cnt_w;
      all_seen = 1'b0;
      en = 1'b0;
      press(4'hF, 6, 6);
      chk("en0_all_strobe", 64'(all_seen), 64'd1);
      chk("en0_counts_held", 64'(cnt_w), 64'(snap));
      en = 1'b1;
      all_seen = 1'b0;
      press(4'hF, 6, 6);
      chk("en1_all_strobe", 64'(all_seen), 64'd1);
      for (int c = 0; c < NC; c++) begin
         ch_val = snap[c*CW +: CW];
         ch_val = CW'((int'(ch_val) + 1) % (MAX + 1));
         chk("en1_count_inc", 64'(cnt_w[c*CW +: CW]), 64'(ch_val));
      end

      // Asynchronous reset while channel 0 is held
      btn = 4'h1;
      repeat (3) step();
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", 64'({cnt_w, cnt_s}), 64'd0);
      chk("async_rst_flags", 64'({ovf_w, prs_w, ovf_s, prs_s}), 64'd0);
      model_reset();
      step();
      rst = 1'b0;
      repeat (5) step();
      chk("post_rst_count0_early", 64'(cnt_w[3:0]), 64'd0);
      step();
      chk("post_rst_count0", 64'(cnt_w[3:0]), 64'd1);
      btn = '0;
      repeat (8) step();

      // Randomised traffic against the model
      for (int t = 0; t < 4000; t++) begin
         for (int c = 0; c < NC; c++) begin
            if ($urandom_range(0, 5) == 0) btn[c] = ~btn[c];
            clr[c] = ($urandom_range(0, 60) == 0);
         end
         dir = 1'($urandom_range(0, 1));
         en  = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
